// File: rtl/lex_shift_encoder.sv
// rtl/lex_shift_encoder.sv - stepping-rotor letter encoder with carry notch
module lex_shift_encoder #(
    parameter int START_OFFSET = 0
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_char,
    input  logic       load,
    input  logic [4:0] load_offset,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_char,
    output logic [4:0] offset,
    output logic       notch
);

    localparam logic [4:0] START_OFF5 = 5'(START_OFFSET);

    logic       accept;
    logic       is_letter;
    logic       step;
    logic [7:0] sum;
    logic [7:0] enc_char;
    logic [4:0] load_red;
    logic [4:0] offset_next;
    logic       notch_next;

    // The output slot can take a new character whenever it is empty or draining.
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign is_letter = (in_char >= 8'h41) && (in_char <= 8'h5A);

    // A letter steps the rotor unless a load overrides it in the same cycle.
    assign step = accept && is_letter && !load;

    // Encode with the current (pre-load) offset; non-letters pass through.
    always_comb begin
        sum = (in_char - 8'h41) + {3'b000, offset};
        if (sum >= 8'd26) begin
            sum = sum - 8'd26;
        end
        enc_char = is_letter ? (sum + 8'h41) : in_char;
    end

    // Next rotor offset: load wins, otherwise advance on letters with 25->0 carry.
    always_comb begin
        load_red    = (load_offset >= 5'd26) ? (load_offset - 5'd26) : load_offset;
        offset_next = offset;
        notch_next  = 1'b0;
        if (load) begin
            offset_next = load_red;
        end else if (step) begin
            if (offset == 5'd25) begin
                offset_next = 5'd0;
                notch_next  = 1'b1;
            end else begin
                offset_next = offset + 5'd1;
            end
        end
    end

    // Rotor offset and one-cycle carry pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            offset <= START_OFF5;
            notch  <= 1'b0;
        end else begin
            offset <= offset_next;
            notch  <= notch_next;
        end
    end

    // Single-entry output register: fill on accept, empty on drain, hold on stall.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_char  <= 8'h00;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_char  <= enc_char;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lex_shift_encoder.sv
// tb/tb_lex_shift_encoder.sv - directed self-checking bench for lex_shift_encoder
module tb_lex_shift_encoder;

    logic       clk;
    logic       resetn;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_char;
    logic       load;
    logic [4:0] load_offset;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_char;
    logic [4:0] offset;
    logic       notch;

    int vectors;
    int miscompares;

    lex_shift_encoder #(.START_OFFSET(0)) dut (
        .clk(clk),
        .resetn(resetn),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_char(in_char),
        .load(load),
        .load_offset(load_offset),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_char(out_char),
        .offset(offset),
        .notch(notch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] c,
                           input logic [4:0] o, input logic n);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        if (v) chk({tag, ".char"}, 32'(out_char), 32'(c));
        chk({tag, ".offset"}, 32'(offset), 32'(o));
        chk({tag, ".notch"}, 32'(notch), 32'(n));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        resetn      = 1'b0;
        in_valid    = 1'b0;
        in_char     = 8'h00;
        load        = 1'b0;
        load_offset = 5'd0;
        out_ready   = 1'b1;

        // reset state
        #1;
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.char", 32'(out_char), 32'h00);
        chk_out("rst", 1'b0, 8'h00, 5'd0, 1'b0);
        tick();
        tick();
        resetn = 1'b1;
        tick();

        // A,B,Z at offset 0 back-to-back
        in_valid = 1'b1; in_char = "A";
        tick(); chk_out("t1.A", 1'b1, "A", 5'd1, 1'b0);
        in_char = "B";
        tick(); chk_out("t1.B", 1'b1, "C", 5'd2, 1'b0);
        in_char = "Z";
        tick(); chk_out("t1.Z", 1'b1, "B", 5'd3, 1'b0);
        in_valid = 1'b0;
        tick(); chk_out("t1.drain", 1'b0, 8'h00, 5'd3, 1'b0);

        // load 25 then wrap with notch
        load = 1'b1; load_offset = 5'd25;
        tick(); chk_out("t2.load", 1'b0, 8'h00, 5'd25, 1'b0);
        load = 1'b0; in_valid = 1'b1; in_char = "B";
        tick(); chk_out("t2.B1", 1'b1, "A", 5'd0, 1'b1);
        tick(); chk_out("t2.B2", 1'b1, "B", 5'd1, 1'b0);
        in_valid = 1'b0;
        tick();

        // reduced load value 31 -> 5 with no character
        load = 1'b1; load_offset = 5'd31;
        tick(); chk_out("t2b.load31", 1'b0, 8'h00, 5'd5, 1'b0);

        // non-letters pass through at offset 4
        load_offset = 5'd4;
        tick(); load = 1'b0;
        in_valid = 1'b1; in_char = 8'h37;
        tick(); chk_out("t3.7", 1'b1, 8'h37, 5'd4, 1'b0);
        in_char = 8'h61;
        tick(); chk_out("t3.a", 1'b1, 8'h61, 5'd4, 1'b0);
        in_char = 8'h00;
        tick(); chk_out("t3.nul", 1'b1, 8'h00, 5'd4, 1'b0);
        in_valid = 1'b0;
        tick();

        // backpressure hold
        load = 1'b1; load_offset = 5'd0;
        tick(); load = 1'b0;
        in_valid = 1'b1; in_char = "C";
        tick(); chk_out("t4.C", 1'b1, "C", 5'd1, 1'b0);
        out_ready = 1'b0; in_char = "D";
        #1; chk("t4.in_ready_lo", 32'(in_ready), 32'd0);
        tick(); chk_out("t4.stall1", 1'b1, "C", 5'd1, 1'b0);
        tick(); chk_out("t4.stall2", 1'b1, "C", 5'd1, 1'b0);
        out_ready = 1'b1; in_char = "E";
        #1; chk("t4.in_ready_hi", 32'(in_ready), 32'd1);
        tick(); chk_out("t4.E", 1'b1, "F", 5'd2, 1'b0);
        in_valid = 1'b0;
        tick();

        // load 30 together with letter Y at offset 2
        load = 1'b1; load_offset = 5'd30; in_valid = 1'b1; in_char = "Y";
        tick(); chk_out("t5.Y", 1'b1, "A", 5'd4, 1'b0);
        load = 1'b0; in_valid = 1'b0;
        tick(); chk_out("t5.after", 1'b0, 8'h00, 5'd4, 1'b0);

        // async reset mid-stream
        out_ready = 1'b0; in_valid = 1'b1; in_char = "A";
        tick(); chk_out("t6.pend", 1'b1, "E", 5'd5, 1'b0);
        in_valid = 1'b0;
        #2; resetn = 1'b0;
        #1; chk_out("t6.rst", 1'b0, 8'h00, 5'd0, 1'b0);
        chk("t6.rst.char", 32'(out_char), 32'h00);
        chk("t6.rst.in_ready", 32'(in_ready), 32'd1);
        tick();
        resetn = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_char = "C";
        tick(); chk_out("t6.after", 1'b1, "C", 5'd1, 1'b0);
        in_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lex_shift_encoder.md
# lex_shift_encoder

Sequential stepping-rotor encoder: the forward (encrypt) counterpart of the bombe's lexicographic subtractor. It accepts a stream of ASCII characters over a valid/ready handshake and adds a rotor offset to each uppercase letter, wrapping 'Z'->'A'. The offset then steps by one, as a rotor advances per keypress. It sits between the keyboard/character source and the downstream rotor/decoder chain, and emits a carry (`notch`) pulse so rotors can be cascaded.

## Interface
- `START_OFFSET`, default 0: rotor offset after reset, range 0..25.
- `clk`  in  1  system clock; all state on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `in_char` is valid.
- `in_ready`  out  1  block can accept a character this cycle.
- `in_char`  in  8  ASCII input character.
- `load`  in  1  load `load_offset` into the rotor offset.
- `load_offset`  in  5  new offset; values 26..31 are reduced by 26.
- `out_valid`  out  1  `out_char` holds an encoded character.
- `out_ready`  in  1  downstream accepts `out_char`.
- `out_char`  out  8  encoded ASCII character.
- `offset`  out  5  current rotor offset, 0..25.
- `notch`  out  1  one-cycle pulse when the offset wraps 25->0.

## Operation
- A character is accepted when `in_valid && in_ready`. Define `in_ready = !out_valid || out_ready`; this is combinational and needs no extra cycle.
- Letter test: 0x41 <= `in_char` <= 0x5A.
- Letter encoding:
  - `idx = in_char - 0x41` (0..25); `sum = idx + offset` (0..50, 6-bit).
  - If `sum >= 26`, subtract 26.
  - `out_char = sum + 0x41`.
  - The offset then steps: 25 -> 0 with `notch` asserted, otherwise +1.
- Non-letter (any other byte, including lowercase and 0x00): passes through unchanged to `out_char`. The offset does not step and there is no `notch`.
- `load`:
  - Next offset = `load_offset` if < 26, else `load_offset - 26`.
  - `load` has priority over stepping.
  - If a letter is accepted in the same cycle as `load`, that letter uses the pre-load offset, the step is discarded, and no `notch` is produced.
- Output register:
  - On accept, `out_char` and `out_valid <= 1` are loaded.
  - When `out_valid && out_ready` with no new accept, `out_valid <= 0`.
  - Accept and drain in the same cycle gives back-to-back throughput.
  - While `out_valid && !out_ready`, `out_char` is held stable.
- State: the offset register (5b), the output register (8b + valid), and the notch flop. No other FSM is needed: the output slot is EMPTY (`out_valid=0`) or FULL (`out_valid=1`).
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on drain without accept.
  - FULL -> FULL on drain with accept, or on stall.

## Timing
- Reset (async, `resetn=0`):
  - `out_valid=0`, `out_char=0x00`, `offset=START_OFFSET`, `notch=0`.
  - `in_ready` is 1 while in reset and after release.
- Latency: the character accepted at edge N appears on `out_char`/`out_valid` after edge N; one cycle.
- `offset` updates at the same edge as the accept. `notch` is registered and high for exactly the cycle following the wrapping accept.
- Throughput: 1 character/cycle while `out_ready=1`.
- Reset asserted mid-stream: a pending output is discarded, and the offset returns to `START_OFFSET` immediately (asynchronously).
- `load` with `in_valid=0`: the offset updates at the next edge. The output is unaffected.

## Test plan
- Reset, offset 0, send 'A','B','Z' with `out_ready=1` -> outputs 'A','C','B' on consecutive cycles; offset ends at 3.
- `load=1`, `load_offset=25`, then send 'B','B' -> outputs 'A' (0x41), then 'B'. `notch` is high for one cycle after the first accept; offset goes 25->0->1.
- Offset 4, send '7' (0x37) then 'a' (0x61) -> both pass through unchanged, offset stays 4, `notch` stays 0.
- Hold `out_ready=0` after one accept ('C' at offset 0), with `in_valid=1` 'D' -> `in_ready=0`, `out_char` stays 'C' and offset stays 1. When `out_ready` rises, 'E' is accepted on that cycle.
- `load=1` with `load_offset=30` in the same cycle as accepting 'Y' at offset 2 -> output 'A', next offset 4, no `notch`.
- Assert `resetn=0` while `out_valid=1` -> `out_valid` drops immediately and offset returns to `START_OFFSET`. After release, the first accept encodes from `START_OFFSET`.
